// File: rtl/next_pc_unit_if.sv
// Fetch-PC bundle between the EX-stage redirect source and the PC unit.
interface next_pc_unit_if;
  logic        stall;
  logic [1:0]  branch_ctrl;
  logic [31:0] pc_ex;
  logic [31:0] imm_ex;
  logic [31:0] rs1_ex;
  logic [31:0] pc_out;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
  logic        misalign_err;

  modport master (
    output stall, branch_ctrl, pc_ex, imm_ex, rs1_ex,
    input  pc_out, flush_if_id, flush_id_ex,
    input  redirect_pending, misalign_err
  );

  modport slave (
    input  stall, branch_ctrl, pc_ex, imm_ex, rs1_ex,
    output pc_out, flush_if_id, flush_id_ex,
    output redirect_pending, misalign_err
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC select with stall-deferred redirects.
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module next_pc_unit (
  input  logic         clk,
  input  logic         rst,
  next_pc_unit_if.slave bus
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {RUN, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {RUN, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target, jalr_sum;
  logic        redirect_req;
  logic        flush;

`ifdef PC_MISALIGN_TRAP_EN
  logic        err_q, err_set;
  logic        bad_target, bad_pend;

  assign bad_target = target[1:0] != 2'b00;
  assign bad_pend   = pend_q[1:0] != 2'b00;
`endif

  always_comb begin
    jalr_sum = bus.rs1_ex + bus.imm_ex;
    target   = bus.pc_ex + bus.imm_ex;
    unique case (1'b1)
      bus.branch_ctrl == 2'b01: target = {jalr_sum[31:1], 1'b0};
      default: ;
    endcase
  end

  assign redirect_req = (bus.branch_ctrl == 2'b01) ||
                        (bus.branch_ctrl == 2'b10);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    err_set = 1'b0;
`endif
    unique case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (redirect_req) begin
            flush = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (bad_target) begin
              err_set = 1'b1;
              state_d = TRAP;
            end else
`endif
            begin
              pc_d = target;
            end
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (redirect_req) begin
          pend_d  = target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // older latched redirect wins; branch_ctrl ignored here
        if (!bus.stall) begin
          flush = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (bad_pend) begin
            err_set = 1'b1;
            state_d = TRAP;
          end else
`endif
          begin
            pc_d    = pend_q;
            state_d = RUN;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= 32'h0000_0000;
      pend_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.pc_out           = pc_q;
  assign bus.flush_if_id      = flush & ~rst;
  assign bus.flush_id_ex      = flush & ~rst;
  assign bus.redirect_pending = state_q == HOLD;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed-vector bench for next_pc_unit.
module tb_next_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  next_pc_unit_if bus ();

  next_pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic [1:0] bc,
                       input logic [31:0] pe, input logic [31:0] im,
                       input logic [31:0] r1);
    bus.stall       = s;
    bus.branch_ctrl = bc;
    bus.pc_ex       = pe;
    bus.imm_ex      = im;
    bus.rs1_ex      = r1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    drive(1'b0, 2'b10, 32'h40, 32'h0, 32'h0);
    #1;
    checks++; if (bus.pc_out !== 32'h0) $display("FAIL reset_pc got %h want 0", bus.pc_out); else passed++;
    checks++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) $display("FAIL reset_flush got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); else passed++;
    checks++; if (bus.redirect_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", bus.redirect_pending); else passed++;
    checks++; if (bus.misalign_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.misalign_err); else passed++;
  endtask

  task automatic test_sequential;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.pc_out !== 32'h0) $display("FAIL seq_pc0 got %h want 0", bus.pc_out); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pc_out !== 32'(i * 4)) $display("FAIL seq_pc%0d got %h want %h", i, bus.pc_out, 32'(i * 4)); else passed++;
      checks++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) $display("FAIL seq_flush%0d got %b%b want 00", i, bus.flush_if_id, bus.flush_id_ex); else passed++;
    end
  endtask

  task automatic test_branch;
    drive(1'b0, 2'b10, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h100) $display("FAIL br_setup got %h want 100", bus.pc_out); else passed++;
    drive(1'b0, 2'b10, 32'hF8, 32'h40, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) $display("FAIL br_flush got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h138) $display("FAIL br_pc got %h want 138", bus.pc_out); else passed++;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) $display("FAIL br_noflush got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h13C) $display("FAIL br_seq got %h want 13c", bus.pc_out); else passed++;
  endtask

  task automatic test_jalr;
    drive(1'b0, 2'b01, 32'h0, 32'h10, 32'h2001);
    #1;
    checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) $display("FAIL jalr_flush got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h2010) $display("FAIL jalr_pc got %h want 2010", bus.pc_out); else passed++;
  endtask

  task automatic test_wrap;
    drive(1'b0, 2'b10, 32'hFFFF_FFF0, 32'hC, 32'h0);
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h want fffffffc", bus.pc_out); else passed++;
    drive(1'b0, 2'b11, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0) $display("FAIL bc11_flush got %b want 0", bus.flush_if_id); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h0) $display("FAIL wrap_pc got %h want 0", bus.pc_out); else passed++;
    drive(1'b0, 2'b10, 32'hFFFF_FFFC, 32'h8, 32'h0);
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h4) $display("FAIL add_mod got %h want 4", bus.pc_out); else passed++;
  endtask

  task automatic test_stall_plain;
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0) $display("FAIL stall_flush got %b want 0", bus.flush_if_id); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h4) $display("FAIL stall_pc got %h want 4", bus.pc_out); else passed++;
    checks++; if (bus.redirect_pending !== 1'b0) $display("FAIL stall_pending got %b want 0", bus.redirect_pending); else passed++;
  endtask

  task automatic test_stall_hold;
    drive(1'b1, 2'b10, 32'h500, 32'h0, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0 || bus.flush_id_ex !== 1'b0) $display("FAIL hold_accept_flush got %b%b want 00", bus.flush_if_id, bus.flush_id_ex); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.redirect_pending !== 1'b1 || bus.pc_out !== 32'h4) $display("FAIL hold_cyc%0d got pend=%b pc=%h want 1/4", i, bus.redirect_pending, bus.pc_out); else passed++;
    end
    drive(1'b1, 2'b01, 32'h0, 32'h0, 32'h900);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0) $display("FAIL hold_new_flush got %b want 0", bus.flush_if_id); else passed++;
    @(negedge clk);
    checks++; if (bus.redirect_pending !== 1'b1 || bus.pc_out !== 32'h4) $display("FAIL hold_new got pend=%b pc=%h want 1/4", bus.redirect_pending, bus.pc_out); else passed++;
    drive(1'b0, 2'b01, 32'h0, 32'h0, 32'h900);
    #1;
    checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) $display("FAIL hold_rel_flush got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h500) $display("FAIL hold_rel_pc got %h want 500", bus.pc_out); else passed++;
    checks++; if (bus.redirect_pending !== 1'b0) $display("FAIL hold_rel_pend got %b want 0", bus.redirect_pending); else passed++;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h504) $display("FAIL hold_after got %h want 504", bus.pc_out); else passed++;
  endtask

  task automatic test_reset_in_hold;
    drive(1'b1, 2'b10, 32'h500, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.redirect_pending !== 1'b1) $display("FAIL rh_pend got %b want 1", bus.redirect_pending); else passed++;
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.pc_out !== 32'h0) $display("FAIL rh_pc got %h want 0", bus.pc_out); else passed++;
    checks++; if (bus.redirect_pending !== 1'b0) $display("FAIL rh_pend0 got %b want 0", bus.redirect_pending); else passed++;
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h4) $display("FAIL rh_release got %h want 4", bus.pc_out); else passed++;
  endtask

  task automatic test_misalign;
    drive(1'b0, 2'b10, 32'h100, 32'h2, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b1 || bus.flush_id_ex !== 1'b1) $display("FAIL mis_flush got %b%b want 11", bus.flush_if_id, bus.flush_id_ex); else passed++;
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if (bus.pc_out !== 32'h4) $display("FAIL mis_pc got %h want 4", bus.pc_out); else passed++;
    checks++; if (bus.misalign_err !== 1'b1) $display("FAIL mis_err got %b want 1", bus.misalign_err); else passed++;
    drive(1'b0, 2'b10, 32'h200, 32'h0, 32'h0);
    #1;
    checks++; if (bus.flush_if_id !== 1'b0) $display("FAIL trap_flush got %b want 0", bus.flush_if_id); else passed++;
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h4 || bus.misalign_err !== 1'b1) $display("FAIL trap_hold got pc=%h err=%b want 4/1", bus.pc_out, bus.misalign_err); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bus.misalign_err !== 1'b0 || bus.pc_out !== 32'h0) $display("FAIL trap_rst got pc=%h err=%b want 0/0", bus.pc_out, bus.misalign_err); else passed++;
    @(negedge clk);
    rst = 1'b0;
`else
    checks++; if (bus.pc_out !== 32'h102) $display("FAIL mis_pc got %h want 102", bus.pc_out); else passed++;
    checks++; if (bus.misalign_err !== 1'b0) $display("FAIL mis_err got %b want 0", bus.misalign_err); else passed++;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h106) $display("FAIL mis_next got %h want 106", bus.pc_out); else passed++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    test_reset;
    test_sequential;
    test_branch;
    test_jalr;
    test_wrap;
    test_stall_plain;
    test_stall_hold;
    test_reset_in_hold;
    test_misalign;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
